// File: rtl/prog_mealy_fsm_if.sv
// Bus bundle for the table-programmable Mealy FSM.
// Master drives control/config, slave returns registered status.
interface prog_mealy_fsm_if #(
    parameter int IN_W  = 2,
    parameter int ST_W  = 2,
    parameter int OUT_W = 1,
    parameter int CNT_W = 16
) ();

    logic                   en;
    logic [IN_W-1:0]        in_vec;
    logic                   cfg_we;
    logic [ST_W+IN_W-1:0]   cfg_addr;
    logic [ST_W+OUT_W-1:0]  cfg_wdata;
    logic                   st_load;
    logic [ST_W-1:0]        st_load_val;
    logic                   err_clr;
    logic [OUT_W-1:0]       o;
    logic [ST_W-1:0]        state;
    logic [CNT_W-1:0]       trans_cnt;
    logic                   err;

    modport master (
        output en,
        output in_vec,
        output cfg_we,
        output cfg_addr,
        output cfg_wdata,
        output st_load,
        output st_load_val,
        output err_clr,
        input  o,
        input  state,
        input  trans_cnt,
        input  err
    );

    modport slave (
        input  en,
        input  in_vec,
        input  cfg_we,
        input  cfg_addr,
        input  cfg_wdata,
        input  st_load,
        input  st_load_val,
        input  err_clr,
        output o,
        output state,
        output trans_cnt,
        output err
    );

endinterface

// File: rtl/prog_mealy_fsm.sv
// Table-programmable Mealy FSM with state load, illegal-state
// recovery, sticky error flag and saturating transition counter.
module prog_mealy_fsm #(
    parameter int IN_W       = 2,
    parameter int ST_W       = 2,
    parameter int NUM_STATES = 4,
    parameter int OUT_W      = 1,
    parameter int CNT_W      = 16
) (
    input  logic           clk,
    input  logic           reset,
    prog_mealy_fsm_if.slave bus
);

    localparam int AW    = ST_W + IN_W;
    localparam int DW    = ST_W + OUT_W;
    localparam int DEPTH = 1 << AW;

    // One extra bit so NUM_STATES == 2^ST_W is representable.
    localparam logic [ST_W:0] NS_LIM = (ST_W+1)'(NUM_STATES);

    logic [DW-1:0]    tbl [DEPTH];

    logic [ST_W-1:0]  state_q;
    logic [OUT_W-1:0] o_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    logic [ST_W-1:0]  state_d;
    logic [OUT_W-1:0] o_d;
    logic [CNT_W-1:0] cnt_d;
    logic             err_d;
    logic             set_err;

    logic [AW-1:0]    rd_addr;
    logic [DW-1:0]    ent;
    logic [ST_W-1:0]  ent_next;
    logic [OUT_W-1:0] ent_out;
    logic             next_ok;
    logic             load_ok;

    logic             do_load;
    logic             do_stall;
    logic             do_step;

    // Reset entry: next state is the state field of the index, out = 0.
    function automatic logic [DW-1:0] self_loop(input int idx);
        return {ST_W'(idx >> IN_W), {OUT_W{1'b0}}};
    endfunction

    // Table storage: reverts to self-loop on reset, cfg writes always land.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= self_loop(i);
            end
        end else if (bus.cfg_we) begin
            tbl[bus.cfg_addr] <= bus.cfg_wdata;
        end
    end

    assign rd_addr  = {state_q, bus.in_vec};
    assign ent      = tbl[rd_addr];
    assign ent_next = ent[DW-1:OUT_W];
    assign ent_out  = ent[OUT_W-1:0];

    assign next_ok  = {1'b0, ent_next} < NS_LIM;
    assign load_ok  = {1'b0, bus.st_load_val} < NS_LIM;

    // Load beats a config write, which stalls stepping.
    assign do_load  = bus.st_load;
    assign do_stall = !bus.st_load && bus.cfg_we;
    assign do_step  = !bus.st_load && !bus.cfg_we && bus.en;

    // Next-state, output and counter selection by operating mode.
    always_comb begin
        state_d = state_q;
        o_d     = o_q;
        cnt_d   = cnt_q;
        set_err = 1'b0;
        unique case (1'b1)
            do_load: begin
                state_d = load_ok ? bus.st_load_val : '0;
                set_err = !load_ok;
                o_d     = '0;
                cnt_d   = '0;
            end
            do_stall: begin
                state_d = state_q;
            end
            do_step: begin
                o_d     = ent_out;
                state_d = next_ok ? ent_next : '0;
                set_err = !next_ok;
                if (state_d != state_q && cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // Sticky error: a new set condition outranks a clear.
    always_comb begin
        err_d = set_err | (err_q & ~bus.err_clr);
    end

    // Registered state, output and counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= '0;
            o_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            o_q     <= o_d;
            cnt_q   <= cnt_d;
        end
    end

    // Error flag register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.state     = state_q;
    assign bus.o         = o_q;
    assign bus.trans_cnt = cnt_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_prog_mealy_fsm.sv
// Directed bench for prog_mealy_fsm: three instances cover
// the full 4-state table, illegal recovery and counter saturation.
module tb_prog_mealy_fsm;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    prog_mealy_fsm_if #(.IN_W(2), .ST_W(2), .OUT_W(1), .CNT_W(16)) bus_a ();
    prog_mealy_fsm_if #(.IN_W(2), .ST_W(2), .OUT_W(1), .CNT_W(16)) bus_b ();
    prog_mealy_fsm_if #(.IN_W(2), .ST_W(2), .OUT_W(1), .CNT_W(3))  bus_c ();

    prog_mealy_fsm #(
        .IN_W(2), .ST_W(2), .NUM_STATES(4), .OUT_W(1), .CNT_W(16)
    ) dut_a (.clk(clk), .reset(reset), .bus(bus_a));

    prog_mealy_fsm #(
        .IN_W(2), .ST_W(2), .NUM_STATES(3), .OUT_W(1), .CNT_W(16)
    ) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    prog_mealy_fsm #(
        .IN_W(2), .ST_W(2), .NUM_STATES(4), .OUT_W(1), .CNT_W(3)
    ) dut_c (.clk(clk), .reset(reset), .bus(bus_c));

    logic [2:0] prog [16] = '{
        3'b000, 3'b111, 3'b010, 3'b100,
        3'b011, 3'b010, 3'b101, 3'b001,
        3'b110, 3'b101, 3'b110, 3'b011,
        3'b001, 3'b111, 3'b101, 3'b011
    };

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_inputs();
        bus_a.en = 0; bus_a.in_vec = 0; bus_a.cfg_we = 0;
        bus_a.cfg_addr = 0; bus_a.cfg_wdata = 0; bus_a.st_load = 0;
        bus_a.st_load_val = 0; bus_a.err_clr = 0;
        bus_b.en = 0; bus_b.in_vec = 0; bus_b.cfg_we = 0;
        bus_b.cfg_addr = 0; bus_b.cfg_wdata = 0; bus_b.st_load = 0;
        bus_b.st_load_val = 0; bus_b.err_clr = 0;
        bus_c.en = 0; bus_c.in_vec = 0; bus_c.cfg_we = 0;
        bus_c.cfg_addr = 0; bus_c.cfg_wdata = 0; bus_c.st_load = 0;
        bus_c.st_load_val = 0; bus_c.err_clr = 0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        total++;
        if ({bus_a.state, bus_a.o, bus_a.err} !== 4'b0 || bus_a.trans_cnt !== 16'd0)
            $display("FAIL reset_a: st=%0d o=%0d err=%0d cnt=%0d want all 0",
                     bus_a.state, bus_a.o, bus_a.err, bus_a.trans_cnt);
        else passed++;
        total++;
        if ({bus_b.state, bus_b.o, bus_b.err} !== 4'b0 || bus_c.trans_cnt !== 3'd0)
            $display("FAIL reset_bc: st=%0d o=%0d err=%0d cnt=%0d want all 0",
                     bus_b.state, bus_b.o, bus_b.err, bus_c.trans_cnt);
        else passed++;
        tick();
        tick();
        @(negedge clk);
        reset = 1'b1;
        bus_a.en = 1;
        for (int i = 0; i < 8; i++) begin
            bus_a.in_vec = 2'(i);
            tick();
            total++;
            if ({bus_a.state, bus_a.o, bus_a.err} !== 4'b0 || bus_a.trans_cnt !== 16'd0)
                $display("FAIL default_sweep[%0d]: st=%0d o=%0d err=%0d cnt=%0d want all 0",
                         i, bus_a.state, bus_a.o, bus_a.err, bus_a.trans_cnt);
            else passed++;
        end
        bus_a.en = 0;
    endtask

    task automatic test_program();
        logic [1:0] ins [4] = '{2'd1, 2'd2, 2'd0, 2'd3};
        logic [1:0] est [4] = '{2'd3, 2'd2, 2'd3, 2'd1};
        logic       eo  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 16; i++) begin
            bus_a.cfg_we = 1;
            bus_a.cfg_addr = 4'(i);
            bus_a.cfg_wdata = prog[i];
            tick();
        end
        bus_a.cfg_we = 0;
        bus_a.en = 1;
        for (int k = 0; k < 4; k++) begin
            bus_a.in_vec = ins[k];
            tick();
            total++;
            if (bus_a.state !== est[k] || bus_a.o !== eo[k])
                $display("FAIL program_step[%0d]: st=%0d o=%0d want st=%0d o=%0d",
                         k, bus_a.state, bus_a.o, est[k], eo[k]);
            else passed++;
        end
        bus_a.en = 0;
        total++;
        if (bus_a.trans_cnt !== 16'd4 || bus_a.err !== 1'b0)
            $display("FAIL program_cnt: cnt=%0d err=%0d want cnt=4 err=0",
                     bus_a.trans_cnt, bus_a.err);
        else passed++;
    endtask

    task automatic test_stall();
        bus_a.en = 1;
        bus_a.in_vec = 2'b00;
        bus_a.cfg_we = 1;
        bus_a.cfg_addr = 4'hF;
        bus_a.cfg_wdata = 3'b011;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                bus_a.cfg_addr = 4'b0100;
                bus_a.cfg_wdata = 3'b100;
            end
            tick();
            total++;
            if (bus_a.state !== 2'd1 || bus_a.o !== 1'b1 || bus_a.trans_cnt !== 16'd4)
                $display("FAIL stall[%0d]: st=%0d o=%0d cnt=%0d want st=1 o=1 cnt=4",
                         i, bus_a.state, bus_a.o, bus_a.trans_cnt);
            else passed++;
        end
        bus_a.cfg_we = 0;
        tick();
        total++;
        if (bus_a.state !== 2'd2 || bus_a.o !== 1'b0 || bus_a.trans_cnt !== 16'd5)
            $display("FAIL write_visible: st=%0d o=%0d cnt=%0d want st=2 o=0 cnt=5",
                     bus_a.state, bus_a.o, bus_a.trans_cnt);
        else passed++;
        bus_a.en = 0;
        bus_a.in_vec = 2'b01;
        tick();
        bus_a.in_vec = 2'b11;
        tick();
        total++;
        if (bus_a.state !== 2'd2 || bus_a.o !== 1'b0 || bus_a.trans_cnt !== 16'd5)
            $display("FAIL en_low_hold: st=%0d o=%0d cnt=%0d want st=2 o=0 cnt=5",
                     bus_a.state, bus_a.o, bus_a.trans_cnt);
        else passed++;
    endtask

    task automatic test_illegal();
        bus_b.cfg_we = 1;
        bus_b.cfg_addr = 4'b0000;
        bus_b.cfg_wdata = 3'b111;
        tick();
        bus_b.cfg_we = 0;
        bus_b.en = 1;
        bus_b.in_vec = 2'b00;
        tick();
        total++;
        if (bus_b.state !== 2'd0 || bus_b.o !== 1'b1 || bus_b.err !== 1'b1 || bus_b.trans_cnt !== 16'd0)
            $display("FAIL illegal_step: st=%0d o=%0d err=%0d cnt=%0d want st=0 o=1 err=1 cnt=0",
                     bus_b.state, bus_b.o, bus_b.err, bus_b.trans_cnt);
        else passed++;
        bus_b.err_clr = 1;
        tick();
        total++;
        if (bus_b.err !== 1'b1)
            $display("FAIL set_beats_clr: err=%0d want 1", bus_b.err);
        else passed++;
        bus_b.en = 0;
        tick();
        bus_b.err_clr = 0;
        total++;
        if (bus_b.err !== 1'b0)
            $display("FAIL err_clr: err=%0d want 0", bus_b.err);
        else passed++;
        bus_b.st_load = 1;
        bus_b.st_load_val = 2'd3;
        tick();
        total++;
        if (bus_b.state !== 2'd0 || bus_b.err !== 1'b1 || bus_b.o !== 1'b0)
            $display("FAIL load_illegal: st=%0d err=%0d o=%0d want st=0 err=1 o=0",
                     bus_b.state, bus_b.err, bus_b.o);
        else passed++;
        bus_b.st_load_val = 2'd2;
        bus_b.err_clr = 1;
        tick();
        bus_b.st_load = 0;
        bus_b.err_clr = 0;
        total++;
        if (bus_b.state !== 2'd2 || bus_b.err !== 1'b0)
            $display("FAIL load_legal: st=%0d err=%0d want st=2 err=0",
                     bus_b.state, bus_b.err);
        else passed++;
    endtask

    task automatic test_saturation();
        logic [1:0] es;
        logic [2:0] ec;
        logic       eo;
        bus_c.cfg_we = 1;
        bus_c.cfg_addr = 4'b0000;
        bus_c.cfg_wdata = 3'b010;
        tick();
        bus_c.cfg_addr = 4'b0100;
        bus_c.cfg_wdata = 3'b001;
        tick();
        bus_c.cfg_we = 0;
        bus_c.en = 1;
        bus_c.in_vec = 2'b00;
        for (int k = 1; k <= 10; k++) begin
            tick();
            es = (k % 2 == 1) ? 2'd1 : 2'd0;
            eo = (k % 2 == 1) ? 1'b0 : 1'b1;
            ec = (k > 7) ? 3'd7 : 3'(k);
            total++;
            if (bus_c.state !== es || bus_c.o !== eo || bus_c.trans_cnt !== ec)
                $display("FAIL sat_step[%0d]: st=%0d o=%0d cnt=%0d want st=%0d o=%0d cnt=%0d",
                         k, bus_c.state, bus_c.o, bus_c.trans_cnt, es, eo, ec);
            else passed++;
        end
        bus_c.en = 0;
        bus_c.st_load = 1;
        bus_c.st_load_val = 2'd1;
        tick();
        bus_c.st_load = 0;
        total++;
        if (bus_c.trans_cnt !== 3'd0 || bus_c.state !== 2'd1 || bus_c.o !== 1'b0)
            $display("FAIL load_cnt_clr: cnt=%0d st=%0d o=%0d want cnt=0 st=1 o=0",
                     bus_c.trans_cnt, bus_c.state, bus_c.o);
        else passed++;
    endtask

    task automatic test_async_reset();
        bus_a.en = 1;
        bus_a.in_vec = 2'b01;
        tick();
        total++;
        if (bus_a.state !== 2'd2 || bus_a.o !== 1'b1)
            $display("FAIL pre_reset: st=%0d o=%0d want st=2 o=1",
                     bus_a.state, bus_a.o);
        else passed++;
        bus_a.en = 0;
        bus_a.cfg_we = 1;
        bus_a.cfg_addr = 4'b0000;
        bus_a.cfg_wdata = 3'b111;
        #2 reset = 1'b0;
        #1;
        total++;
        if ({bus_a.state, bus_a.o, bus_a.err} !== 4'b0 || bus_a.trans_cnt !== 16'd0)
            $display("FAIL async_clear_a: st=%0d o=%0d err=%0d cnt=%0d want all 0",
                     bus_a.state, bus_a.o, bus_a.err, bus_a.trans_cnt);
        else passed++;
        total++;
        if (bus_c.state !== 2'd0)
            $display("FAIL async_clear_c: st=%0d want 0", bus_c.state);
        else passed++;
        bus_a.cfg_we = 0;
        @(negedge clk);
        reset = 1'b1;
        bus_a.en = 1;
        for (int i = 0; i < 4; i++) begin
            bus_a.in_vec = 2'(i);
            tick();
            total++;
            if (bus_a.state !== 2'd0 || bus_a.o !== 1'b0 || bus_a.trans_cnt !== 16'd0)
                $display("FAIL post_reset[%0d]: st=%0d o=%0d cnt=%0d want all 0",
                         i, bus_a.state, bus_a.o, bus_a.trans_cnt);
            else passed++;
        end
        bus_a.en = 0;
    endtask

    initial begin
        init_inputs();
        test_reset();
        test_program();
        test_stall();
        test_illegal();
        test_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
